// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared state encoding and width helpers for the sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef logic [1:0] state_e;

    localparam state_e IDLE = 2'd0;
    localparam state_e CALC = 2'd1;
    localparam state_e FIX  = 2'd2;
    localparam state_e DONE = 2'd3;

    // Step counter must be at least one bit wide even for the smallest legal WIDTH.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int product_w(input int width);
        return 2 * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_accum.sv
// ============================================================================
// Module : mult_accum
// Brief  : Partial-product accumulator P with init / add / negate / hold controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_accum #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic          i_add,
    input  logic          i_negate,
    input  logic [PW-1:0] i_addend,
    output logic [PW-1:0] o_acc,
    output logic [PW-1:0] o_acc_next
);

    logic [PW-1:0] acc_q;
    logic [PW-1:0] acc_d;

    // Sums wrap modulo 2^PW; the full product always fits so no carry-out is kept.
    always_comb begin
        acc_d = acc_q;
        if (i_init) begin
            acc_d = '0;
        end else if (i_add) begin
            acc_d = acc_q + i_addend;
        end else if (i_negate) begin
            acc_d = -acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc      = acc_q;
    assign o_acc_next = acc_d;

endmodule

`default_nettype wire

// File: rtl/seq_mult_core.sv
// ============================================================================
// Module : seq_mult_core
// Brief  : Shift-add sequential multiplier with valid/ready handshakes.
//          Optional MULT_SIGNED_EN enables two's-complement operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mult_core
    import mult_pkg::*;
#(
    parameter  int WIDTH     = 8,
    localparam int CNT_W     = cnt_w(WIDTH),
    localparam int PRODUCT_W = product_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_signed,
    input  logic                 clear,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [PRODUCT_W-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic                   neg_q,     neg_d;
    logic [PRODUCT_W-1:0]   product_q, product_d;

    logic                   w_acc_init;
    logic                   w_acc_add;
    logic                   w_acc_neg;
    logic [PRODUCT_W-1:0]   w_acc;
    logic [PRODUCT_W-1:0]   w_acc_next;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic                   w_neg;

`ifdef MULT_SIGNED_EN
    // Magnitude of -2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
    assign w_mag_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_mag_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign w_neg   = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
    logic w_unused_signed;
    assign w_unused_signed = op_signed;
    assign w_mag_a         = op_a;
    assign w_mag_b         = op_b;
    assign w_neg           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        neg_d      = neg_q;
        product_d  = product_q;
        w_acc_init = 1'b0;
        w_acc_add  = 1'b0;
        w_acc_neg  = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d    = CALC;
                        mcand_d    = {{WIDTH{1'b0}}, w_mag_a};
                        mplier_d   = w_mag_b;
                        cnt_d      = '0;
                        neg_d      = w_neg;
                        w_acc_init = 1'b1;
                    end
                end
                CALC: begin
                    w_acc_add = mplier_q[0];
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    w_acc_neg = neg_q;
                    product_d = w_acc_next;
                    state_d   = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    mult_accum #(
        .PW (PRODUCT_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_acc_init),
        .i_add      (w_acc_add),
        .i_negate   (w_acc_neg),
        .i_addend   (mcand_q),
        .o_acc      (w_acc),
        .o_acc_next (w_acc_next)
    );

    logic [PRODUCT_W-1:0] w_unused_acc;
    assign w_unused_acc = w_acc;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

`default_nettype wire
